pipe_field: RTL
===============

PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 3, number of pipe columns (1..8).
REQ-002 SHALL have parameter PIPE_W, default 40, pipe width in pixels.
REQ-003 SHALL have parameter GAP_H, default 120, vertical gap height in pixels.
REQ-004 SHALL have parameter SPACING, default 220, horizontal pitch between pipe right edges.
REQ-005 SHALL have parameters SCREEN_W = 640, SCREEN_H = 480, SPEED_MAX = 4, GAP_MIN = 40; GAP_MIN+255+GAP_H < SCREEN_H SHALL be enforced by elaboration assertion.
REQ-006 SHALL have ports: Clk input 1 system clock; Reset_n input 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: frame_clk input 1 (VGA_VS, asynchronous); start input 1 (one-Clk pulse).
REQ-008 SHALL have ports: BirdX, BirdY, BirdS input 10 each (bird centre and half-size); DrawX, DrawY input 10 each (current pixel).
REQ-009 SHALL have ports: pipe_on output 1 (pixel inside a pipe); collide output 1 (one-Clk pulse); score output 8; game_state output 2 (IDLE=0, RUN=1, OVER=2).

Function
REQ-010 frame_clk SHALL pass a 2-flop synchroniser plus rising-edge detector; the internal tick SHALL be asserted for one Clk, 3 Clk after the rising edge.
REQ-011 Each pipe i SHALL hold an 11-bit right edge R[i] and an 8-bit gap offset G[i]; gap top = GAP_MIN+G[i], gap bottom = gap top+GAP_H.
REQ-012 Init values: R[i] = SCREEN_W+PIPE_W+i*SPACING, G[i] = 128, score = 0, speed = 1.
REQ-013 FSM IDLE: values held at init; start -> RUN on next Clk.
REQ-014 FSM RUN, on tick only: every R[i] -= speed; if R[i] <= speed, R[i] SHALL become R[i]+NUM_PIPES*SPACING-speed and G[i] SHALL load the LFSR low byte.
REQ-015 Score SHALL increment by 1 per pipe whose R crosses from > BirdX-BirdS to <= BirdX-BirdS in that tick; saturates at 255; two pipes crossing in one tick add 2.
REQ-016 Speed SHALL increment by 1 whenever score reaches a non-zero multiple of 8, saturating at SPEED_MAX.
REQ-017 Collision SHALL be evaluated on tick using pre-move values: horizontal overlap (BirdX-BirdS < R[i] and BirdX+BirdS >= R[i]-PIPE_W) and (BirdY-BirdS < gap top or BirdY+BirdS > gap bottom), or BirdY+BirdS >= SCREEN_H.
REQ-018 On collision: collide pulses 1 Clk, FSM -> OVER, no position update and no score increment in that tick (collision wins over score).
REQ-019 FSM OVER: all state frozen; start -> reload init values and enter RUN on next Clk.
REQ-020 start in RUN SHALL be ignored; tick in IDLE/OVER SHALL be ignored.
REQ-021 pipe_on SHALL be combinational: 1 when some i has DrawX+PIPE_W >= R[i] and DrawX < R[i] and (DrawY < gap top or DrawY >= gap bottom); valid in every state.
REQ-022 16-bit Galois LFSR (taps 16,14,13,11) SHALL advance every Clk in all states; it shall never be all-zero.

Reset
REQ-023 Reset_n low SHALL asynchronously force IDLE, init values, LFSR = 16'hACE1, synchroniser flops = 0, collide = 0, score = 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the frame without partial pipe updates; first tick after release SHALL be ignored unless start has occurred.

Structure
REQ-025 Package flappy_pkg SHALL hold game_state_t enum, LFSR_SEED, LFSR taps constant, and GAP_MIN default.
REQ-026 Sub-module pipe_lfsr (Clk, Reset_n, 16-bit value out) SHALL implement REQ-022; pipe arrays SHALL use generate loops over NUM_PIPES.

Verification
REQ-027 Reset then start, 10 frame_clk edges, bird far left (BirdX=20): R[0] = 680-10 = 670, score 0, game_state 1.
REQ-028 Bird at BirdX=100,BirdS=6,BirdY=GAP_MIN+128+60 (gap centre) for 600 frames: score increments exactly when each R passes 94, no collide, speed reaches 2 at score 8.
REQ-029 Bird BirdY=20 with pipe overlapping: collide pulses once, game_state 2, R/score unchanged over 5 further ticks.
REQ-030 Pipe with R=1, speed=1: next tick R = 1+660-1 = 660, G = LFSR low byte sampled that Clk.
REQ-031 Score crossing and collision in same tick: score unchanged, game_state 2; then start -> init values, game_state 1.
REQ-032 Reset_n pulsed low mid-RUN between ticks: all outputs to reset values immediately, pipe_on matches init layout at DrawX=660,DrawY=0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe field game logic.
package flappy_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StOver = 2'd2
    } game_state_t;

    localparam logic [15:0] LFSR_SEED       = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;
    localparam int          GAP_MIN_DEFAULT = 40;
    localparam logic [7:0]  GAP_INIT        = 8'd128;

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 16-bit Galois LFSR used to randomise gap offsets; never reaches all-zero.
module pipe_lfsr
    import flappy_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field: pipe positions and gaps, scoring, collision and the game FSM.
// Per-frame updates are driven by a synchronised rising edge of frame_clk.
module pipe_field
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 3,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int SPACING   = 220,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPEED_MAX = 4,
    parameter int GAP_MIN   = GAP_MIN_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start,
    input  logic [9:0] BirdX,
    input  logic [9:0] BirdY,
    input  logic [9:0] BirdS,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       pipe_on,
    output logic       collide,
    output logic [7:0] score,
    output logic [1:0] game_state
);

    if (GAP_MIN + 255 + GAP_H >= SCREEN_H) begin : g_bad_gap
        $error("pipe_field: GAP_MIN + 255 + GAP_H must be below SCREEN_H");
    end
    if (NUM_PIPES < 1 || NUM_PIPES > 8) begin : g_bad_pipes
        $error("pipe_field: NUM_PIPES must be 1..8");
    end
    if (SPEED_MAX < 1 || SPEED_MAX > 15) begin : g_bad_speed
        $error("pipe_field: SPEED_MAX must be 1..15");
    end

    localparam logic [10:0]        WRAP_W      = 11'(NUM_PIPES * SPACING);
    localparam logic signed [12:0] PIPE_W_S    = 13'(PIPE_W);
    localparam logic signed [12:0] GAP_MIN_S   = 13'(GAP_MIN);
    localparam logic signed [12:0] GAP_H_S     = 13'(GAP_H);
    localparam logic signed [12:0] SCREEN_H_S  = 13'(SCREEN_H);
    localparam logic [3:0]         SPEED_MAX_W = 4'(SPEED_MAX);

    game_state_t          state_q, state_d;
    logic [7:0]           score_q, score_d;
    logic [3:0]           speed_q, speed_d;
    logic                 collide_q, collide_d;
    logic                 fs1_q, fs2_q, fs3_q, tick_q;
    logic                 load_init, move_en, floor_hit;
    logic [NUM_PIPES-1:0] hit, crossed, on;
    logic [3:0]           cross_cnt;
    logic [8:0]           score_sum;
    logic [15:0]          lfsr_val;
    logic                 unused_lfsr_hi;

    logic signed [12:0] bird_l, bird_r, bird_t, bird_b, draw_x, draw_y;

    pipe_lfsr u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .value_o (lfsr_val)
    );

    assign unused_lfsr_hi = ^lfsr_val[15:8];

    assign bird_l = $signed({3'b000, BirdX}) - $signed({3'b000, BirdS});
    assign bird_r = $signed({3'b000, BirdX}) + $signed({3'b000, BirdS});
    assign bird_t = $signed({3'b000, BirdY}) - $signed({3'b000, BirdS});
    assign bird_b = $signed({3'b000, BirdY}) + $signed({3'b000, BirdS});
    assign draw_x = $signed({3'b000, DrawX});
    assign draw_y = $signed({3'b000, DrawY});
    assign floor_hit = (bird_b >= SCREEN_H_S);

    // frame_clk is asynchronous: two sync flops, a history flop, then a registered one-Clk tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1_q  <= 1'b0;
            fs2_q  <= 1'b0;
            fs3_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            fs1_q  <= frame_clk;
            fs2_q  <= fs1_q;
            fs3_q  <= fs2_q;
            tick_q <= fs2_q & ~fs3_q;
        end
    end

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        localparam logic [10:0] R_INIT = 11'(SCREEN_W + PIPE_W + i * SPACING);

        logic [10:0]        r_q, r_d, r_mv;
        logic [7:0]         g_q, g_d;
        logic               wrap;
        logic signed [12:0] r_s, r_mv_s, gap_top, gap_bot;

        assign wrap    = (r_q <= {7'b0, speed_q});
        assign r_mv    = wrap ? (r_q + WRAP_W - {7'b0, speed_q}) : (r_q - {7'b0, speed_q});
        assign r_s     = $signed({2'b00, r_q});
        assign r_mv_s  = $signed({2'b00, r_mv});
        assign gap_top = GAP_MIN_S + $signed({5'b00000, g_q});
        assign gap_bot = gap_top + GAP_H_S;

        assign hit[i]     = (bird_l < r_s) && (bird_r >= r_s - PIPE_W_S) &&
                            ((bird_t < gap_top) || (bird_b > gap_bot));
        assign crossed[i] = (r_s > bird_l) && (r_mv_s <= bird_l);
        assign on[i]      = (draw_x + PIPE_W_S >= r_s) && (draw_x < r_s) &&
                            ((draw_y < gap_top) || (draw_y >= gap_bot));

        always_comb begin
            r_d = r_q;
            g_d = g_q;
            if (load_init) begin
                r_d = R_INIT;
                g_d = GAP_INIT;
            end else if (move_en) begin
                r_d = r_mv;
                if (wrap) begin
                    g_d = lfsr_val[7:0];
                end
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_q <= R_INIT;
                g_q <= GAP_INIT;
            end else begin
                r_q <= r_d;
                g_q <= g_d;
            end
        end
    end

    always_comb begin
        cross_cnt = 4'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            cross_cnt = cross_cnt + 4'(crossed[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        speed_d   = speed_q;
        collide_d = 1'b0;
        load_init = 1'b0;
        move_en   = 1'b0;
        score_sum = {1'b0, score_q} + {5'b00000, cross_cnt};
        case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d   = StRun;
                    load_init = 1'b1;
                    score_d   = 8'd0;
                    speed_d   = 4'd1;
                end
            end
            StRun: begin
                if (tick_q) begin
                    // Collision is judged on pre-move positions and suppresses the move and score.
                    if ((|hit) || floor_hit) begin
                        collide_d = 1'b1;
                        state_d   = StOver;
                    end else begin
                        move_en = 1'b1;
                        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                        if ((score_d[7:3] != score_q[7:3]) && (score_d != 8'd0) &&
                            (speed_q < SPEED_MAX_W)) begin
                            speed_d = speed_q + 4'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            score_q   <= 8'd0;
            speed_q   <= 4'd1;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            speed_q   <= speed_d;
            collide_q <= collide_d;
        end
    end

    assign pipe_on    = |on;
    assign collide    = collide_q;
    assign score      = score_q;
    assign game_state = state_q;

endmodule
